cmd_frame_decoder: RTL and testbench
====================================

// Module: cmd_frame_decoder
// PURPOSE
//  Assembles the host UART byte stream into commands: 1 opcode byte, then 0 or PAYLOAD_BYTES payload bytes.
//  Opcode[7]=1 selects a long command with payload; opcode[7]=0 selects a short command with no payload.
//  Sits between uart_rx and the capture-control register file.
//  Adds an inter-byte timeout, an output valid/ready handshake and overrun reporting.
// PARAMETERS
//  PAYLOAD_BYTES   4        payload bytes per long command, 1..8
//  BIG_ENDIAN      0        0: first payload byte -> command[7:0]; 1: first byte -> command[MSB-:8]
//  TIMEOUT_CYCLES  1000000  clocks allowed between payload bytes before abort; 0 disables the timeout
// PORTS
//  clock          in   1                  system clock, all logic on rising edge
//  reset          in   1                  asynchronous, active-low
//  byte_in_valid  in   1                  one-cycle strobe, byte_in is valid
//  byte_in        in   8                  received byte
//  cmd_valid      out  1                  command held on outputs until accepted
//  cmd_ready      in   1                  consumer accepts when cmd_valid && cmd_ready
//  opcode         out  8                  opcode of the held command
//  command        out  8*PAYLOAD_BYTES    payload of the held command; all zero for short commands
//  cmd_long       out  1                  held command is a long command
//  err_timeout    out  1                  one-cycle pulse, partial long command discarded
//  err_overrun    out  1                  one-cycle pulse, byte dropped while in HOLD
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; byte_cnt and timer cleared.
//   All outputs are 0: cmd_valid, opcode, command, cmd_long, err_*.
//  States:
//   IDLE: on byte_in_valid, latch the opcode and clear command.
//    opcode[7]=0 -> HOLD. opcode[7]=1 -> PAYLOAD with byte_cnt=0 and timer=0.
//   PAYLOAD: on byte_in_valid, store the byte in slot byte_cnt (endianness per BIG_ENDIAN), byte_cnt++, timer=0.
//    byte_cnt==PAYLOAD_BYTES-1 on that byte -> HOLD.
//    If no byte arrives, timer++. When timer==TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES!=0) -> IDLE.
//    The timeout pulses err_timeout for 1 cycle, discards the partial command and leaves cmd_valid low.
//   HOLD: cmd_valid=1; opcode, command and cmd_long are stable.
//    cmd_ready=1 -> IDLE next cycle, and cmd_valid drops that same next cycle.
//  Latency: cmd_valid rises the cycle after the final byte strobe (opcode for short, last payload byte for long).
//  byte_cnt width is $clog2(PAYLOAD_BYTES+1). Timer width is $clog2(TIMEOUT_CYCLES+1), and it saturates.
//  Simultaneous events:
//   HOLD with byte_in_valid and cmd_ready both high: handshake completes and the byte is processed as an IDLE opcode.
//    cmd_valid may then re-assert 1 cycle later for a short opcode. No overrun is flagged.
//   HOLD with byte_in_valid and cmd_ready low: byte dropped, err_overrun pulses, held command unchanged.
//   PAYLOAD, byte arrives the same cycle the timer expires: the byte wins and the timer is cleared.
//  Reset mid-operation: the partial command is discarded with no err_* pulse. Outputs are as above.
//  Only opcode[7] is decoded; opcode meaning belongs downstream.
// STRUCTURE
//  Package cmd_decoder_pkg:
//   state_t enum {IDLE, PAYLOAD, HOLD}.
//   LONG_CMD_BIT=7.
//   Opcode constants: CMD_RESET=8'h00, CMD_RUN=8'h01, CMD_ID=8'h02, CMD_SET_DIV=8'h80, CMD_SET_CNT=8'h81, CMD_SET_MASK=8'hC0.
//  Sub-module cmd_timeout_timer handles the timeout:
//   clear and enable inputs, an expired output.
//   TIMEOUT_CYCLES parameter; 0 means never expire.
//  The FSM uses a separate state register and a combinational next-state block.
//  Datapath registers are written only in clocked blocks.
// TESTING
//  1 Short opcode 8'h01, cmd_ready=1 -> cmd_valid high exactly 1 cycle, 1 cycle after the strobe.
//     opcode=01, cmd_long=0, command=0.
//  2 Long 80,11,22,33,44 with BIG_ENDIAN=0 -> command=32'h44332211, cmd_long=1.
//     Repeat with BIG_ENDIAN=1 -> command=32'h11223344.
//  3 TIMEOUT_CYCLES=16; send 81,AA then idle 20 clocks.
//     -> err_timeout pulses 1 cycle, cmd_valid never rises.
//     Next 01 decodes cleanly as a short command.
//  4 Hold cmd_ready=0 after a command completes; send byte 55.
//     -> err_overrun 1 cycle, outputs unchanged.
//     Then cmd_ready=1 together with byte 02 -> handshake completes, then opcode=02 valid 1 cycle later.
//  5 Drive reset low after 80,11,22 -> all outputs 0 and no err_* pulse.
//     After release, 80,01,02,03,04 decodes to 32'h04030201.
//  6 PAYLOAD_BYTES=8, back-to-back strobes every cycle, 3 frames -> 3 correct commands.
//     cmd_ready=1 throughout, no err_* pulses.

Source files
------------

// File: rtl/cmd_frame_decoder_pkg.sv
// Shared types and constants for the host command frame decoder.
//   state_t      : frame assembly state (IDLE, PAYLOAD, HOLD)
//   LONG_CMD_BIT : opcode bit that selects a long (payload-carrying) command
//   CMD_*        : known opcode values, decoded downstream only
package cmd_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    HOLD
  } state_t;

  localparam int unsigned LONG_CMD_BIT = 7;

  localparam logic [7:0] CMD_RESET    = 8'h00;
  localparam logic [7:0] CMD_RUN      = 8'h01;
  localparam logic [7:0] CMD_ID       = 8'h02;
  localparam logic [7:0] CMD_SET_DIV  = 8'h80;
  localparam logic [7:0] CMD_SET_CNT  = 8'h81;
  localparam logic [7:0] CMD_SET_MASK = 8'hC0;

endpackage

// File: rtl/cmd_frame_decoder_if.sv
// Byte-stream input and command-output handshake of the frame decoder.
//   byte_in_valid/byte_in : one-cycle byte strobe from the UART receiver
//   cmd_valid/cmd_ready   : held-command handshake towards the register file
//   opcode/command/cmd_long : fields of the held command
//   err_timeout/err_overrun : one-cycle error pulses
// slave  : decoder side
// master : byte source / command consumer side
interface cmd_frame_decoder_if #(
  parameter int unsigned PAYLOAD_BYTES = 4
);

  logic                         byte_in_valid;
  logic [7:0]                   byte_in;
  logic                         cmd_valid;
  logic                         cmd_ready;
  logic [7:0]                   opcode;
  logic [8*PAYLOAD_BYTES-1:0]   command;
  logic                         cmd_long;
  logic                         err_timeout;
  logic                         err_overrun;

  modport slave (
    input  byte_in_valid, byte_in, cmd_ready,
    output cmd_valid, opcode, command, cmd_long, err_timeout, err_overrun
  );

  modport master (
    output byte_in_valid, byte_in, cmd_ready,
    input  cmd_valid, opcode, command, cmd_long, err_timeout, err_overrun
  );

endinterface

// File: rtl/cmd_frame_decoder_timeout.sv
// Inter-byte timeout counter for the frame decoder.
//   clock, reset : system clock, asynchronous active-low reset
//   clear        : restart the count at zero
//   enable       : count one idle clock
//   expired      : combinational, high on the idle clock that reaches the limit
// TIMEOUT_CYCLES = 0 disables expiry entirely. The counter saturates.
module cmd_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned TW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;

  always_comb begin
    timer_d = timer_q;
    if (clear) begin
      timer_d = '0;
    end else if (enable && (timer_q != '1)) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_never
      assign expired = 1'b0;
    end else begin : g_limit
      assign expired = enable && (timer_q == TW'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/cmd_frame_decoder.sv
// Assembles the host UART byte stream into commands: one opcode byte, then
// PAYLOAD_BYTES payload bytes when opcode[7] is set, none otherwise.
//   clock, reset : system clock, asynchronous active-low reset
//   bus          : byte input strobe, held-command handshake and error pulses
// Parameters:
//   PAYLOAD_BYTES  : payload bytes per long command (1..8)
//   BIG_ENDIAN     : 0 puts the first payload byte in command[7:0], 1 in the top byte
//   TIMEOUT_CYCLES : idle clocks allowed between payload bytes, 0 disables
module cmd_frame_decoder
  import cmd_decoder_pkg::*;
#(
  parameter int unsigned PAYLOAD_BYTES  = 4,
  parameter bit          BIG_ENDIAN     = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clock,
  input  logic                 reset,
  cmd_frame_decoder_if.slave   bus
);

  localparam int unsigned CW    = 8 * PAYLOAD_BYTES;
  localparam int unsigned CNT_W = $clog2(PAYLOAD_BYTES + 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]        opcode_q, opcode_d;
  logic [CW-1:0]     command_q, command_d;
  logic              cmd_long_q, cmd_long_d;
  logic              err_timeout_q, err_timeout_d;
  logic              err_overrun_q, err_overrun_d;

  logic              take_opcode;
  logic              timer_clear;
  logic              timer_enable;
  logic              timer_expired;

  // A byte in the same cycle as expiry keeps the timer from counting, so the
  // byte always wins over the timeout.
  assign timer_clear  = (state_q != PAYLOAD) || bus.byte_in_valid;
  assign timer_enable = (state_q == PAYLOAD) && !bus.byte_in_valid;

  cmd_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    opcode_d      = opcode_q;
    command_d     = command_q;
    cmd_long_d    = cmd_long_q;
    err_timeout_d = 1'b0;
    err_overrun_d = 1'b0;
    take_opcode   = 1'b0;

    unique case (state_q)
      IDLE: begin
        take_opcode = bus.byte_in_valid;
      end

      PAYLOAD: begin
        if (bus.byte_in_valid) begin
          for (int unsigned i = 0; i < PAYLOAD_BYTES; i++) begin
            if (byte_cnt_q == CNT_W'(i)) begin
              command_d[8*(BIG_ENDIAN ? (PAYLOAD_BYTES - 1 - i) : i) +: 8] = bus.byte_in;
            end
          end
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == CNT_W'(PAYLOAD_BYTES - 1)) begin
            state_d = HOLD;
          end
        end else if (timer_expired) begin
          state_d       = IDLE;
          err_timeout_d = 1'b1;
          opcode_d      = '0;
          command_d     = '0;
          cmd_long_d    = 1'b0;
        end
      end

      HOLD: begin
        // Handshake and a new byte in one cycle: the byte is decoded exactly as
        // it would be in IDLE, so a short opcode lands straight back in HOLD.
        if (bus.cmd_ready) begin
          state_d     = IDLE;
          take_opcode = bus.byte_in_valid;
        end else if (bus.byte_in_valid) begin
          err_overrun_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (take_opcode) begin
      opcode_d   = bus.byte_in;
      command_d  = '0;
      cmd_long_d = bus.byte_in[LONG_CMD_BIT];
      byte_cnt_d = '0;
      state_d    = bus.byte_in[LONG_CMD_BIT] ? PAYLOAD : HOLD;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      byte_cnt_q    <= '0;
      opcode_q      <= '0;
      command_q     <= '0;
      cmd_long_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      opcode_q      <= opcode_d;
      command_q     <= command_d;
      cmd_long_q    <= cmd_long_d;
      err_timeout_q <= err_timeout_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign bus.cmd_valid   = (state_q == HOLD);
  assign bus.opcode      = opcode_q;
  assign bus.command     = command_q;
  assign bus.cmd_long    = cmd_long_q;
  assign bus.err_timeout = err_timeout_q;
  assign bus.err_overrun = err_overrun_q;

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Bench for cmd_frame_decoder. Three decoders share one byte stream:
//   dut_a : 4 payload bytes, little-endian, 16-clock timeout
//   dut_b : 4 payload bytes, big-endian,    16-clock timeout
//   dut_c : 8 payload bytes, little-endian, timeout disabled
module tb_cmd_frame_decoder;
  import cmd_decoder_pkg::*;

  localparam int unsigned TMO = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       byte_in_valid;
  logic [7:0] byte_in;
  logic       cmd_ready;

  int checks = 0;
  int errors = 0;
  int tmo_a = 0, tmo_c = 0, ovr_a = 0, ovr_c = 0;

  always #5 clock = ~clock;

  cmd_frame_decoder_if #(.PAYLOAD_BYTES(4)) if_a ();
  cmd_frame_decoder_if #(.PAYLOAD_BYTES(4)) if_b ();
  cmd_frame_decoder_if #(.PAYLOAD_BYTES(8)) if_c ();

  assign if_a.byte_in_valid = byte_in_valid;
  assign if_a.byte_in       = byte_in;
  assign if_a.cmd_ready     = cmd_ready;
  assign if_b.byte_in_valid = byte_in_valid;
  assign if_b.byte_in       = byte_in;
  assign if_b.cmd_ready     = cmd_ready;
  assign if_c.byte_in_valid = byte_in_valid;
  assign if_c.byte_in       = byte_in;
  assign if_c.cmd_ready     = cmd_ready;

  cmd_frame_decoder #(.PAYLOAD_BYTES(4), .BIG_ENDIAN(1'b0), .TIMEOUT_CYCLES(TMO))
    dut_a (.clock(clock), .reset(reset), .bus(if_a));
  cmd_frame_decoder #(.PAYLOAD_BYTES(4), .BIG_ENDIAN(1'b1), .TIMEOUT_CYCLES(TMO))
    dut_b (.clock(clock), .reset(reset), .bus(if_b));
  cmd_frame_decoder #(.PAYLOAD_BYTES(8), .BIG_ENDIAN(1'b0), .TIMEOUT_CYCLES(0))
    dut_c (.clock(clock), .reset(reset), .bus(if_c));

  // Error pulse tallies; a pulse visible during a cycle is counted at the next rising edge.
  always @(posedge clock) begin
    if (if_a.err_timeout === 1'b1) tmo_a++;
    if (if_c.err_timeout === 1'b1) tmo_c++;
    if (if_a.err_overrun === 1'b1) ovr_a++;
    if (if_c.err_overrun === 1'b1) ovr_c++;
  end

  // Reference packing: payload byte i lands at byte position i (little-endian)
  // or n-1-i (big-endian) of the command word.
  function automatic logic [63:0] pack(input logic [7:0] pl [0:7], input int unsigned n, input bit be);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < n; i++) begin
      int unsigned pos;
      pos = be ? (n - 1 - i) : i;
      r = r | (64'(pl[i]) << (8 * pos));
    end
    return r;
  endfunction

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in_valid = 1'b1;
    byte_in       = b;
    @(negedge clock);
    byte_in_valid = 1'b0;
    byte_in       = '0;
  endtask

  task automatic test_reset;
    reset = 1'b0; byte_in_valid = 1'b0; byte_in = '0; cmd_ready = 1'b0;
    wait_cycles(3);
    checks++;
    if ({if_a.cmd_valid, if_a.cmd_long, if_a.err_timeout, if_a.err_overrun} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags_a: got %b expected 0000",
        {if_a.cmd_valid, if_a.cmd_long, if_a.err_timeout, if_a.err_overrun});
    end
    checks++;
    if (if_a.opcode !== 8'h00 || if_a.command !== 32'h0) begin
      errors++; $display("FAIL reset_data_a: got opcode=%h command=%h expected 00/0", if_a.opcode, if_a.command);
    end
    checks++;
    if (if_b.cmd_valid !== 1'b0 || if_b.command !== 32'h0) begin
      errors++; $display("FAIL reset_b: got valid=%b command=%h expected 0/0", if_b.cmd_valid, if_b.command);
    end
    checks++;
    if (if_c.cmd_valid !== 1'b0 || if_c.command !== 64'h0 || if_c.opcode !== 8'h00) begin
      errors++; $display("FAIL reset_c: got valid=%b opcode=%h command=%h expected zeros",
        if_c.cmd_valid, if_c.opcode, if_c.command);
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_short;
    cmd_ready = 1'b1;
    checks++;
    if (if_a.cmd_valid !== 1'b0) begin
      errors++; $display("FAIL short_pre_valid: got %b expected 0", if_a.cmd_valid);
    end
    send_byte(CMD_RUN);
    checks++;
    if (if_a.cmd_valid !== 1'b1 || if_a.opcode !== CMD_RUN) begin
      errors++; $display("FAIL short_valid: got valid=%b opcode=%h expected 1/%h", if_a.cmd_valid, if_a.opcode, CMD_RUN);
    end
    checks++;
    if (if_a.cmd_long !== 1'b0 || if_a.command !== 32'h0) begin
      errors++; $display("FAIL short_fields: got long=%b command=%h expected 0/0", if_a.cmd_long, if_a.command);
    end
    @(negedge clock);
    checks++;
    if (if_a.cmd_valid !== 1'b0) begin
      errors++; $display("FAIL short_one_cycle: got valid=%b expected 0", if_a.cmd_valid);
    end
    cmd_ready = 1'b0;
  endtask

  task automatic test_long;
    logic [7:0]  pl [0:7];
    logic [63:0] exp_le, exp_be;
    pl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_le = pack(pl, 4, 1'b0);
    exp_be = pack(pl, 4, 1'b1);
    cmd_ready = 1'b0;
    send_byte(CMD_SET_DIV);
    for (int i = 0; i < 4; i++) begin
      send_byte(pl[i]);
      if (i == 2) begin
        checks++;
        if (if_a.cmd_valid !== 1'b0) begin
          errors++; $display("FAIL long_early_valid: got %b expected 0", if_a.cmd_valid);
        end
      end
    end
    checks++;
    if (if_a.cmd_valid !== 1'b1 || if_a.opcode !== CMD_SET_DIV || if_a.cmd_long !== 1'b1) begin
      errors++; $display("FAIL long_hdr: got valid=%b opcode=%h long=%b expected 1/80/1",
        if_a.cmd_valid, if_a.opcode, if_a.cmd_long);
    end
    checks++;
    if (if_a.command !== exp_le[31:0]) begin
      errors++; $display("FAIL long_le: got %h expected %h", if_a.command, exp_le[31:0]);
    end
    checks++;
    if (if_b.command !== exp_be[31:0]) begin
      errors++; $display("FAIL long_be: got %h expected %h", if_b.command, exp_be[31:0]);
    end
    cmd_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (if_a.cmd_valid !== 1'b0) begin
      errors++; $display("FAIL long_accept: got valid=%b expected 0", if_a.cmd_valid);
    end
    cmd_ready = 1'b0;
  endtask

  task automatic test_timeout;
    int t0, tc0, pulses, pos;
    bit valid_seen;
    t0 = tmo_a; tc0 = tmo_c; pulses = 0; pos = 0; valid_seen = 1'b0;
    cmd_ready = 1'b1;
    send_byte(CMD_SET_CNT);
    send_byte(8'hAA);
    // The abort follows TMO consecutive byte-less clocks.
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (if_a.err_timeout === 1'b1) begin pulses++; pos = i; end
      if (if_a.cmd_valid !== 1'b0) valid_seen = 1'b1;
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL timeout_pulse_width: got %0d cycles expected 1", pulses);
    end
    checks++;
    if (pos != int'(TMO)) begin
      errors++; $display("FAIL timeout_pulse_pos: got idle cycle %0d expected %0d", pos, TMO);
    end
    checks++;
    if (valid_seen) begin
      errors++; $display("FAIL timeout_valid: got cmd_valid high expected never");
    end
    send_byte(CMD_RUN);
    checks++;
    if (if_a.cmd_valid !== 1'b1 || if_a.opcode !== CMD_RUN || if_a.cmd_long !== 1'b0 || if_a.command !== 32'h0) begin
      errors++; $display("FAIL timeout_recover: got valid=%b opcode=%h long=%b command=%h expected 1/01/0/0",
        if_a.cmd_valid, if_a.opcode, if_a.cmd_long, if_a.command);
    end
    wait_cycles(2);
    checks++;
    if (tmo_c - tc0 != 0) begin
      errors++; $display("FAIL timeout_disabled: got %0d pulses expected 0", tmo_c - tc0);
    end
    checks++;
    if (tmo_a - t0 != 1) begin
      errors++; $display("FAIL timeout_count: got %0d pulses expected 1", tmo_a - t0);
    end
    cmd_ready = 1'b0;
  endtask

  task automatic test_timeout_boundary;
    logic [7:0]  pl [0:7];
    logic [63:0] exp_le;
    int t0;
    t0 = tmo_a;
    pl = '{8'h5A, 8'hC3, 8'h0F, 8'hE1, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_le = pack(pl, 4, 1'b0);
    cmd_ready = 1'b0;
    send_byte(CMD_SET_MASK);
    // Each byte arrives on the very clock that would otherwise abort the frame.
    for (int i = 0; i < 4; i++) begin
      wait_cycles(TMO - 1);
      send_byte(pl[i]);
    end
    checks++;
    if (if_a.cmd_valid !== 1'b1 || if_a.command !== exp_le[31:0] || if_a.opcode !== CMD_SET_MASK) begin
      errors++; $display("FAIL boundary_cmd: got valid=%b opcode=%h command=%h expected 1/%h/%h",
        if_a.cmd_valid, if_a.opcode, if_a.command, CMD_SET_MASK, exp_le[31:0]);
    end
    cmd_ready = 1'b1;
    @(negedge clock);
    cmd_ready = 1'b0;
    @(negedge clock);
    checks++;
    if (tmo_a - t0 != 0) begin
      errors++; $display("FAIL boundary_no_timeout: got %0d pulses expected 0", tmo_a - t0);
    end
  endtask

  task automatic test_overrun;
    int o0;
    o0 = ovr_a;
    cmd_ready = 1'b0;
    send_byte(CMD_RUN);
    send_byte(8'h55);
    checks++;
    if (if_a.err_overrun !== 1'b1) begin
      errors++; $display("FAIL overrun_pulse: got %b expected 1", if_a.err_overrun);
    end
    checks++;
    if (if_a.cmd_valid !== 1'b1 || if_a.opcode !== CMD_RUN || if_a.cmd_long !== 1'b0 || if_a.command !== 32'h0) begin
      errors++; $display("FAIL overrun_hold: got valid=%b opcode=%h long=%b command=%h expected 1/01/0/0",
        if_a.cmd_valid, if_a.opcode, if_a.cmd_long, if_a.command);
    end
    @(negedge clock);
    checks++;
    if (if_a.err_overrun !== 1'b0 || if_a.opcode !== CMD_RUN) begin
      errors++; $display("FAIL overrun_one_cycle: got ovr=%b opcode=%h expected 0/01", if_a.err_overrun, if_a.opcode);
    end
    cmd_ready = 1'b1;
    send_byte(CMD_ID);
    checks++;
    if (if_a.cmd_valid !== 1'b1 || if_a.opcode !== CMD_ID || if_a.err_overrun !== 1'b0) begin
      errors++; $display("FAIL overrun_chain: got valid=%b opcode=%h ovr=%b expected 1/02/0",
        if_a.cmd_valid, if_a.opcode, if_a.err_overrun);
    end
    @(negedge clock);
    checks++;
    if (if_a.cmd_valid !== 1'b0) begin
      errors++; $display("FAIL overrun_chain_accept: got valid=%b expected 0", if_a.cmd_valid);
    end
    cmd_ready = 1'b0;
    @(negedge clock);
    checks++;
    if (ovr_a - o0 != 1) begin
      errors++; $display("FAIL overrun_count: got %0d pulses expected 1", ovr_a - o0);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0]  pl [0:7];
    logic [63:0] exp_le, exp_be;
    int t0, o0;
    t0 = tmo_a; o0 = ovr_a;
    cmd_ready = 1'b1;
    send_byte(CMD_SET_DIV);
    send_byte(8'h11);
    send_byte(8'h22);
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({if_a.cmd_valid, if_a.cmd_long, if_a.err_timeout, if_a.err_overrun} !== 4'b0000 ||
        if_a.opcode !== 8'h00 || if_a.command !== 32'h0) begin
      errors++; $display("FAIL midreset_async: got valid=%b opcode=%h command=%h expected zeros",
        if_a.cmd_valid, if_a.opcode, if_a.command);
    end
    wait_cycles(2);
    reset = 1'b1;
    pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
    exp_le = pack(pl, 4, 1'b0);
    exp_be = pack(pl, 4, 1'b1);
    cmd_ready = 1'b0;
    send_byte(CMD_SET_DIV);
    for (int i = 0; i < 4; i++) send_byte(pl[i]);
    checks++;
    if (if_a.cmd_valid !== 1'b1 || if_a.command !== exp_le[31:0]) begin
      errors++; $display("FAIL midreset_le: got valid=%b command=%h expected 1/%h", if_a.cmd_valid, if_a.command, exp_le[31:0]);
    end
    checks++;
    if (if_b.command !== exp_be[31:0]) begin
      errors++; $display("FAIL midreset_be: got %h expected %h", if_b.command, exp_be[31:0]);
    end
    cmd_ready = 1'b1;
    @(negedge clock);
    cmd_ready = 1'b0;
    @(negedge clock);
    checks++;
    if (tmo_a - t0 != 0 || ovr_a - o0 != 0) begin
      errors++; $display("FAIL midreset_no_err: got tmo=%0d ovr=%0d expected 0/0", tmo_a - t0, ovr_a - o0);
    end
  endtask

  task automatic test_random;
    logic [7:0]  pl [0:7];
    logic [63:0] exp_le, exp_be;
    logic [7:0]  op;
    int unsigned n;
    int t0, o0;
    t0 = tmo_a; o0 = ovr_a;
    cmd_ready = 1'b0;
    for (int f = 0; f < 25; f++) begin
      op = 8'($urandom);
      n  = op[7] ? 4 : 0;
      for (int i = 0; i < 8; i++) pl[i] = (i < int'(n)) ? 8'($urandom) : 8'h00;
      exp_le = pack(pl, n, 1'b0);
      exp_be = pack(pl, n, 1'b1);
      send_byte(op);
      for (int i = 0; i < int'(n); i++) begin
        wait_cycles($urandom_range(0, 3));
        send_byte(pl[i]);
      end
      checks++;
      if (if_a.cmd_valid !== 1'b1 || if_a.opcode !== op || if_a.cmd_long !== op[7] || if_a.command !== exp_le[31:0]) begin
        errors++; $display("FAIL rand_a[%0d]: got valid=%b opcode=%h long=%b command=%h expected 1/%h/%b/%h",
          f, if_a.cmd_valid, if_a.opcode, if_a.cmd_long, if_a.command, op, op[7], exp_le[31:0]);
      end
      checks++;
      if (if_b.command !== exp_be[31:0]) begin
        errors++; $display("FAIL rand_b[%0d]: got %h expected %h", f, if_b.command, exp_be[31:0]);
      end
      wait_cycles($urandom_range(0, 3));
      checks++;
      if (if_a.cmd_valid !== 1'b1 || if_a.opcode !== op) begin
        errors++; $display("FAIL rand_stall[%0d]: got valid=%b opcode=%h expected 1/%h", f, if_a.cmd_valid, if_a.opcode, op);
      end
      cmd_ready = 1'b1;
      @(negedge clock);
      cmd_ready = 1'b0;
      checks++;
      if (if_a.cmd_valid !== 1'b0) begin
        errors++; $display("FAIL rand_accept[%0d]: got valid=%b expected 0", f, if_a.cmd_valid);
      end
    end
    @(negedge clock);
    checks++;
    if (tmo_a - t0 != 0 || ovr_a - o0 != 0) begin
      errors++; $display("FAIL rand_no_err: got tmo=%0d ovr=%0d expected 0/0", tmo_a - t0, ovr_a - o0);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0]  stream [$];
    logic [7:0]  exp_op [$];
    logic [63:0] exp_cmd [$];
    logic [7:0]  pl [0:7];
    logic [7:0]  op;
    int got, tc0, oc0;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    for (int f = 0; f < 3; f++) begin
      op = 8'h80 | 8'($urandom_range(0, 127));
      stream.push_back(op);
      exp_op.push_back(op);
      for (int i = 0; i < 8; i++) begin
        pl[i] = 8'($urandom);
        stream.push_back(pl[i]);
      end
      exp_cmd.push_back(pack(pl, 8, 1'b0));
    end
    got = 0; tc0 = tmo_c; oc0 = ovr_c;
    cmd_ready = 1'b1;
    for (int i = 0; i < stream.size(); i++) begin
      byte_in_valid = 1'b1;
      byte_in       = stream[i];
      @(negedge clock);
      if (if_c.cmd_valid === 1'b1) begin
        if (got < 3) begin
          checks++;
          if (if_c.opcode !== exp_op[got] || if_c.command !== exp_cmd[got] || if_c.cmd_long !== 1'b1) begin
            errors++; $display("FAIL b2b_cmd[%0d]: got opcode=%h long=%b command=%h expected %h/1/%h",
              got, if_c.opcode, if_c.cmd_long, if_c.command, exp_op[got], exp_cmd[got]);
          end
        end
        got++;
      end
    end
    byte_in_valid = 1'b0;
    byte_in       = '0;
    wait_cycles(2);
    cmd_ready = 1'b0;
    checks++;
    if (got != 3) begin
      errors++; $display("FAIL b2b_count: got %0d commands expected 3", got);
    end
    checks++;
    if (tmo_c - tc0 != 0 || ovr_c - oc0 != 0) begin
      errors++; $display("FAIL b2b_no_err: got tmo=%0d ovr=%0d expected 0/0", tmo_c - tc0, ovr_c - oc0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_short;
    test_long;
    test_timeout;
    test_timeout_boundary;
    test_overrun;
    test_reset_mid;
    test_random;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
